// File: rtl/multiplexed_display_controller.sv
// N-digit multiplexed seven-segment scanner with a single clock, frame-coherent
// input snapshots, PWM brightness, per-digit blink/dp masks and leading-zero blanking.
module multiplexed_display_controller #(
    parameter int unsigned NUMBER_OF_DIGITS            = 4,
    parameter int unsigned REFRESH_RATE_IN_HERTZ       = 500,
    parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int unsigned BLINK_RATE_IN_HERTZ         = 2,
    parameter int unsigned BRIGHTNESS_BITS             = 4,
    localparam int unsigned IW = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [4*NUMBER_OF_DIGITS-1:0]   number,
    input  logic [NUMBER_OF_DIGITS-1:0]     dp_mask,
    input  logic [NUMBER_OF_DIGITS-1:0]     blink_mask,
    input  logic                            blank_leading_zeros,
    input  logic [BRIGHTNESS_BITS-1:0]      brightness,
    output logic [NUMBER_OF_DIGITS-1:0]     io_sel,
    output logic [7:0]                      io_seg,
    output logic [IW-1:0]                   digit_index,
    output logic                            frame_start
);

    localparam int unsigned TICKS_PER_DIGIT =
        BOARD_CLOCK_FREQUENCY_IN_HZ / REFRESH_RATE_IN_HERTZ / NUMBER_OF_DIGITS;
    localparam int unsigned SLOT_STEP         = TICKS_PER_DIGIT >> BRIGHTNESS_BITS;
    localparam int unsigned BLINK_HALF_PERIOD =
        BOARD_CLOCK_FREQUENCY_IN_HZ / (2 * BLINK_RATE_IN_HERTZ);
    localparam int unsigned TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam int unsigned BW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam int unsigned NW = 4 * NUMBER_OF_DIGITS;

    // Active-low segment pattern {g,f,e,d,c,b,a} for a hex value
    function automatic logic [6:0] decode_hex(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [TW-1:0]              tick_q, tick_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [BW-1:0]              blink_cnt_q, blink_cnt_d;
    logic                       blink_phase_q, blink_phase_d;

    logic [NW-1:0]              num_snap_q;
    logic [NUMBER_OF_DIGITS-1:0] dp_snap_q, blink_snap_q;
    logic                       blank_snap_q;
    logic [BRIGHTNESS_BITS-1:0] bright_snap_q;

    logic [NUMBER_OF_DIGITS-1:0] io_sel_d;
    logic [7:0]                  io_seg_d;
    logic [IW-1:0]               digit_index_d;
    logic                        frame_start_d;

    logic                        snap_load;
    logic [NW-1:0]               num_eff;
    logic [NUMBER_OF_DIGITS-1:0] dp_eff, blink_eff;
    logic                        blank_eff;
    logic [BRIGHTNESS_BITS-1:0]  bright_eff;

    logic [NUMBER_OF_DIGITS-1:0] lz_vec;
    logic                        zero_above;
    logic [3:0]                  cur_digit;
    logic                        cur_dp, cur_blink, cur_blank;
    logic [31:0]                 duty_limit;
    logic                        lit;

    // Scan counters and free-running blink timer
    always_comb begin
        tick_d        = tick_q + TW'(1);
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (tick_q == TW'(TICKS_PER_DIGIT - 1)) begin
            tick_d = '0;
            idx_d  = (idx_q == IW'(NUMBER_OF_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        if (blink_cnt_q == BW'(BLINK_HALF_PERIOD - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // The (0,0) slot is displayed from the values being captured that same
    // cycle, so the whole frame, including its first cycle, sees one snapshot.
    always_comb begin
        snap_load  = (idx_q == '0) && (tick_q == '0);
        num_eff    = snap_load ? number              : num_snap_q;
        dp_eff     = snap_load ? dp_mask             : dp_snap_q;
        blink_eff  = snap_load ? blink_mask          : blink_snap_q;
        blank_eff  = snap_load ? blank_leading_zeros : blank_snap_q;
        bright_eff = snap_load ? brightness          : bright_snap_q;
    end

    // Output decode for the digit at the current (index, tick)
    always_comb begin
        lz_vec     = '0;
        zero_above = 1'b1;
        for (int i = NUMBER_OF_DIGITS - 1; i >= 1; i--) begin
            if (zero_above && (num_eff[4*i +: 4] == 4'd0)) begin
                lz_vec[i] = 1'b1;
            end else begin
                zero_above = 1'b0;
            end
        end

        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_digit = num_eff[4*i +: 4];
                cur_dp    = dp_eff[i];
                cur_blink = blink_eff[i];
                cur_blank = lz_vec[i];
            end
        end

        duty_limit = (32'(bright_eff) + 32'd1) * 32'(SLOT_STEP);
        lit        = enable && (32'(tick_q) < duty_limit) && !(cur_blink && !blink_phase_q);

        io_sel_d = '1;
        for (int i = 0; i < NUMBER_OF_DIGITS; i++) begin
            if (lit && (idx_q == IW'(i))) begin
                io_sel_d[i] = 1'b0;
            end
        end

        io_seg_d      = {~cur_dp, (blank_eff && cur_blank) ? 7'h7F : decode_hex(cur_digit)};
        digit_index_d = idx_q;
        frame_start_d = snap_load;
    end

    // State, snapshot and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_q        <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            num_snap_q    <= '0;
            dp_snap_q     <= '0;
            blink_snap_q  <= '0;
            blank_snap_q  <= 1'b0;
            bright_snap_q <= '0;
            io_sel        <= '1;
            io_seg        <= 8'hFF;
            digit_index   <= '0;
            frame_start   <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            if (snap_load) begin
                num_snap_q    <= number;
                dp_snap_q     <= dp_mask;
                blink_snap_q  <= blink_mask;
                blank_snap_q  <= blank_leading_zeros;
                bright_snap_q <= brightness;
            end
            io_sel        <= io_sel_d;
            io_seg        <= io_seg_d;
            digit_index   <= digit_index_d;
            frame_start   <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_multiplexed_display_controller.sv
// Scoreboard bench: a cycle-count reference model pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_multiplexed_display_controller;

    localparam int N      = 4;
    localparam int BOARD  = 1600;
    localparam int REFR   = 100;
    localparam int BLINK  = 50;
    localparam int BB     = 2;
    localparam int TICKS  = BOARD / REFR / N;
    localparam int SLOT   = TICKS >> BB;
    localparam int HALF   = BOARD / (2 * BLINK);
    localparam int FRAME  = TICKS * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [4*N-1:0] number;
    logic [N-1:0]  dp_mask, blink_mask;
    logic          blank_leading_zeros;
    logic [BB-1:0] brightness;
    logic [N-1:0]  io_sel;
    logic [7:0]    io_seg;
    logic [1:0]    digit_index;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    multiplexed_display_controller #(
        .NUMBER_OF_DIGITS            (N),
        .REFRESH_RATE_IN_HERTZ       (REFR),
        .BOARD_CLOCK_FREQUENCY_IN_HZ (BOARD),
        .BLINK_RATE_IN_HERTZ         (BLINK),
        .BRIGHTNESS_BITS             (BB)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable              (enable),
        .number              (number),
        .dp_mask             (dp_mask),
        .blink_mask          (blink_mask),
        .blank_leading_zeros (blank_leading_zeros),
        .brightness          (brightness),
        .io_sel              (io_sel),
        .io_seg              (io_seg),
        .digit_index         (digit_index),
        .frame_start         (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
        logic [1:0] idx;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Active-low {g..a} patterns for hex digits
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: everything derived from the cycle count t since reset release
    int         t;
    int         m_d, m_tick;
    logic       m_phase, m_lit, m_blanked;
    logic [15:0] s_num;
    logic [3:0] s_dp, s_blink, m_val;
    logic       s_blank;
    logic [1:0] s_bright;
    exp_t       e_in;

    always @(posedge clk) begin
        if (!rst) begin
            e_in.sel = 4'hF;
            e_in.seg = 8'hFF;
            e_in.idx = 2'd0;
            e_in.fs  = 1'b0;
            t = 0;
        end else begin
            if (t % FRAME == 0) begin
                s_num    = number;
                s_dp     = dp_mask;
                s_blink  = blink_mask;
                s_blank  = blank_leading_zeros;
                s_bright = brightness;
            end
            m_d       = (t / TICKS) % N;
            m_tick    = t % TICKS;
            m_phase   = ((t / HALF) % 2) == 0;
            m_lit     = enable && (m_tick < (int'(s_bright) + 1) * SLOT)
                        && !(s_blink[m_d] && !m_phase);
            m_val     = 4'((s_num >> (4 * m_d)) & 16'hF);
            m_blanked = s_blank && (m_d > 0) && ((s_num >> (4 * m_d)) == 16'd0);
            e_in.sel  = m_lit ? ~(4'b0001 << m_d) : 4'hF;
            e_in.seg  = {~s_dp[m_d], m_blanked ? 7'h7F : seg_tab[m_val]};
            e_in.idx  = 2'(m_d);
            e_in.fs   = (t % FRAME) == 0;
            t++;
        end
        exp_q.push_back(e_in);
    end

    // Monitor: compare every presented output cycle against the scoreboard
    exp_t e_out;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_out = exp_q.pop_front();
            chk("io_sel", 32'(io_sel), 32'(e_out.sel));
            chk("io_seg", 32'(io_seg), 32'(e_out.seg));
            chk("digit_index", 32'(digit_index), 32'(e_out.idx));
            chk("frame_start", 32'(frame_start), 32'(e_out.fs));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b1;
        number = 16'h1234;
        dp_mask = '0;
        blink_mask = '0;
        blank_leading_zeros = 1'b0;
        brightness = 2'd3;
        cyc(3);
        chk("reset_sel", 32'(io_sel), 32'hF);
        chk("reset_seg", 32'(io_seg), 32'hFF);
        rst = 1'b1;
        cyc(1);
        chk("first_sel", 32'(io_sel), 32'b1110);
        chk("first_seg", 32'(io_seg), 32'b10011001);
        chk("first_fs", 32'(frame_start), 32'd1);
        // Change the value during digit 1 of the first frame
        cyc(4);
        number = 16'h5678;
        cyc(40);
        number = 16'h0070;
        blank_leading_zeros = 1'b1;
        cyc(32);
        blank_leading_zeros = 1'b0;
        cyc(32);
        brightness = 2'd0;
        cyc(32);
        brightness = 2'd3;
        blink_mask = 4'b0010;
        cyc(64);
        blink_mask = '0;
        dp_mask = 4'b0100;
        cyc(32);
        cyc(2);
        enable = 1'b0;
        cyc(10);
        enable = 1'b1;
        cyc(5);
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(20);
        for (int k = 0; k < 80; k++) begin
            number              = 16'($urandom);
            if ($urandom_range(0, 3) == 0) number = number & 16'h00FF;
            dp_mask             = 4'($urandom);
            blink_mask          = 4'($urandom);
            blank_leading_zeros = 1'($urandom);
            brightness          = 2'($urandom);
            enable              = ($urandom_range(0, 5) != 0);
            rst                 = ($urandom_range(0, 15) != 0);
            cyc($urandom_range(1, 20));
            rst = 1'b1;
        end
        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
